// File: rtl/axi4_lite_master_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_master_arbiter_if
// Brief    : Command/completion bus between the arbiter and one axi4_lite_master.
// Revision : 1.0
// ============================================================================
interface axi4_lite_master_arbiter_if #(
    parameter int G_DATA_WIDTH = 32,
    parameter int G_ADDR_WIDTH = 32
);
    logic                      m_start;
    logic [G_ADDR_WIDTH-1:0]   m_addr;
    logic                      m_rnw;
    logic [G_DATA_WIDTH/8-1:0] m_strobe;
    logic [G_DATA_WIDTH-1:0]   m_wdata;
    logic                      m_done;
    logic [G_DATA_WIDTH-1:0]   m_rdata;
    logic [1:0]                m_access_status;

    modport master (
        output m_start, m_addr, m_rnw, m_strobe, m_wdata,
        input  m_done, m_rdata, m_access_status
    );

    modport slave (
        input  m_start, m_addr, m_rnw, m_strobe, m_wdata,
        output m_done, m_rdata, m_access_status
    );
endinterface
`default_nettype wire

// File: rtl/axi4_lite_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi4_lite_master_arbiter
// Brief    : Two-requester round-robin arbiter in front of one AXI4-Lite master.
//            Optional WAIT timeout enabled by defining AXI4_LITE_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module axi4_lite_master_arbiter #(
    parameter int G_DATA_WIDTH = 32,
    parameter int G_ADDR_WIDTH = 32,
    parameter int G_TIMEOUT    = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      req0_start,
    input  logic [G_ADDR_WIDTH-1:0]   req0_addr,
    input  logic                      req0_rnw,
    input  logic [G_DATA_WIDTH/8-1:0] req0_strobe,
    input  logic [G_DATA_WIDTH-1:0]   req0_wdata,
    output logic                      req0_done,
    output logic [G_DATA_WIDTH-1:0]   req0_rdata,
    output logic [1:0]                req0_status,
    input  logic                      req1_start,
    input  logic [G_ADDR_WIDTH-1:0]   req1_addr,
    input  logic                      req1_rnw,
    input  logic [G_DATA_WIDTH/8-1:0] req1_strobe,
    input  logic [G_DATA_WIDTH-1:0]   req1_wdata,
    output logic                      req1_done,
    output logic [G_DATA_WIDTH-1:0]   req1_rdata,
    output logic [1:0]                req1_status,
    axi4_lite_master_arbiter_if.master m_bus
);
    localparam int         C_STRB_W = G_DATA_WIDTH / 8;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    logic [1:0]              state_q, state_d;
    logic [1:0]              pend_q;
    logic                    grant_q, grant_d;
    logic                    rr_q;
    logic [1:0]              done_q;
    logic [G_ADDR_WIDTH-1:0] addr_q   [2];
    logic                    rnw_q    [2];
    logic [C_STRB_W-1:0]     strb_q   [2];
    logic [G_DATA_WIDTH-1:0] wdata_q  [2];
    logic [G_DATA_WIDTH-1:0] rdata_q  [2];
    logic [1:0]              status_q [2];
    logic [G_ADDR_WIDTH-1:0] m_addr_q;
    logic                    m_rnw_q;
    logic [C_STRB_W-1:0]     m_strb_q;
    logic [G_DATA_WIDTH-1:0] m_wdata_q;

    logic [1:0]              w_start;
    logic [G_ADDR_WIDTH-1:0] w_addr  [2];
    logic                    w_rnw   [2];
    logic [C_STRB_W-1:0]     w_strb  [2];
    logic [G_DATA_WIDTH-1:0] w_wdata [2];
    logic                    w_complete;
    logic [G_DATA_WIDTH-1:0] w_rdata;
    logic [1:0]              w_status;

    assign w_start    = {req1_start, req0_start};
    assign w_addr[0]  = req0_addr;
    assign w_addr[1]  = req1_addr;
    assign w_rnw[0]   = req0_rnw;
    assign w_rnw[1]   = req1_rnw;
    assign w_strb[0]  = req0_strobe;
    assign w_strb[1]  = req1_strobe;
    assign w_wdata[0] = req0_wdata;
    assign w_wdata[1] = req1_wdata;

    // rr_q names the tie winner; it only advances when both requesters contend.
    assign grant_d = (&pend_q) ? rr_q : pend_q[1];

`ifdef AXI4_LITE_ARB_TIMEOUT_EN
    localparam int C_CNT_W = $clog2(G_TIMEOUT) + 1;

    logic [C_CNT_W-1:0] wait_cnt_q;
    logic               w_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
        end else if (state_q != S_WAIT) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_q + C_CNT_W'(1);
        end
    end

    assign w_timeout  = (wait_cnt_q == C_CNT_W'(G_TIMEOUT - 1));
    assign w_complete = (state_q == S_WAIT) && (m_bus.m_done || w_timeout);
    assign w_rdata    = m_bus.m_done ? m_bus.m_rdata : '0;
    assign w_status   = m_bus.m_done ? m_bus.m_access_status : 2'b11;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = ^G_TIMEOUT;
    assign w_complete       = (state_q == S_WAIT) && m_bus.m_done;
    assign w_rdata          = m_bus.m_rdata;
    assign w_status         = m_bus.m_access_status;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|pend_q) state_d = S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT:  if (w_complete) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            pend_q    <= '0;
            grant_q   <= 1'b0;
            rr_q      <= 1'b0;
            done_q    <= '0;
            m_addr_q  <= '0;
            m_rnw_q   <= 1'b0;
            m_strb_q  <= '0;
            m_wdata_q <= '0;
            for (int i = 0; i < 2; i++) begin
                addr_q[i]   <= '0;
                rnw_q[i]    <= 1'b0;
                strb_q[i]   <= '0;
                wdata_q[i]  <= '0;
                rdata_q[i]  <= '0;
                status_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            done_q  <= '0;
            for (int i = 0; i < 2; i++) begin
                if (w_start[i] && !pend_q[i]) begin
                    pend_q[i]  <= 1'b1;
                    addr_q[i]  <= w_addr[i];
                    rnw_q[i]   <= w_rnw[i];
                    strb_q[i]  <= w_strb[i];
                    wdata_q[i] <= w_wdata[i];
                end
            end
            if ((state_q == S_IDLE) && (|pend_q)) begin
                grant_q   <= grant_d;
                m_addr_q  <= addr_q[grant_d];
                m_rnw_q   <= rnw_q[grant_d];
                m_strb_q  <= strb_q[grant_d];
                m_wdata_q <= wdata_q[grant_d];
                if (&pend_q) rr_q <= ~rr_q;
            end
            if (w_complete) begin
                pend_q[grant_q]   <= 1'b0;
                done_q[grant_q]   <= 1'b1;
                rdata_q[grant_q]  <= w_rdata;
                status_q[grant_q] <= w_status;
            end
        end
    end

    assign m_bus.m_start  = (state_q == S_ISSUE);
    assign m_bus.m_addr   = m_addr_q;
    assign m_bus.m_rnw    = m_rnw_q;
    assign m_bus.m_strobe = m_strb_q;
    assign m_bus.m_wdata  = m_wdata_q;

    assign req0_done   = done_q[0];
    assign req1_done   = done_q[1];
    assign req0_rdata  = rdata_q[0];
    assign req1_rdata  = rdata_q[1];
    assign req0_status = status_q[0];
    assign req1_status = status_q[1];
endmodule
`default_nettype wire

// File: tb/tb_axi4_lite_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi4_lite_master_arbiter
// Brief    : Directed and randomized bench for axi4_lite_master_arbiter.
// Revision : 1.0
// ============================================================================
module tb_axi4_lite_master_arbiter;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int SW = DW / 8;
    localparam int TO = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic          rnw;
        logic [SW-1:0] strb;
        logic [DW-1:0] wdata;
    } cmd_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          req0_start = 1'b0, req1_start = 1'b0;
    logic [AW-1:0] req0_addr = '0, req1_addr = '0;
    logic          req0_rnw = 1'b0, req1_rnw = 1'b0;
    logic [SW-1:0] req0_strobe = '0, req1_strobe = '0;
    logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
    logic          req0_done, req1_done;
    logic [DW-1:0] req0_rdata, req1_rdata;
    logic [1:0]    req0_status, req1_status;

    axi4_lite_master_arbiter_if #(.G_DATA_WIDTH(DW), .G_ADDR_WIDTH(AW)) bus ();

    axi4_lite_master_arbiter #(
        .G_DATA_WIDTH(DW), .G_ADDR_WIDTH(AW), .G_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_start(req0_start), .req0_addr(req0_addr), .req0_rnw(req0_rnw),
        .req0_strobe(req0_strobe), .req0_wdata(req0_wdata),
        .req0_done(req0_done), .req0_rdata(req0_rdata), .req0_status(req0_status),
        .req1_start(req1_start), .req1_addr(req1_addr), .req1_rnw(req1_rnw),
        .req1_strobe(req1_strobe), .req1_wdata(req1_wdata),
        .req1_done(req1_done), .req1_rdata(req1_rdata), .req1_status(req1_status),
        .m_bus(bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit tie_winner = 1'b0;   // requester expected to win the next simultaneous request

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    function automatic cmd_t rand_cmd();
        cmd_t c;
        c.addr  = $urandom;
        c.rnw   = 1'($urandom_range(0, 1));
        c.strb  = SW'($urandom);
        c.wdata = $urandom;
        return c;
    endfunction

    function automatic cmd_t bus_cmd();
        return {bus.m_addr, bus.m_rnw, bus.m_strobe, bus.m_wdata};
    endfunction

    function automatic logic done_of(input int n);
        return (n == 0) ? req0_done : req1_done;
    endfunction

    function automatic logic [DW-1:0] rdata_of(input int n);
        return (n == 0) ? req0_rdata : req1_rdata;
    endfunction

    function automatic logic [1:0] status_of(input int n);
        return (n == 0) ? req0_status : req1_status;
    endfunction

    function automatic logic [159:0] all_out();
        return {req0_done, req1_done, req0_rdata, req1_rdata, req0_status, req1_status,
                bus.m_start, bus.m_addr, bus.m_rnw, bus.m_strobe, bus.m_wdata};
    endfunction

    task automatic drive_req(input int n, input logic s, input cmd_t c);
        if (n == 0) begin
            req0_start = s; req0_addr = c.addr; req0_rnw = c.rnw;
            req0_strobe = c.strb; req0_wdata = c.wdata;
        end else begin
            req1_start = s; req1_addr = c.addr; req1_rnw = c.rnw;
            req1_strobe = c.strb; req1_wdata = c.wdata;
        end
    endtask

    task automatic pulse(input int n, input cmd_t c);
        drive_req(n, 1'b1, c);
        step();
        drive_req(n, 1'b0, rand_cmd());
    endtask

    task automatic pulse_both(input cmd_t c0, input cmd_t c1);
        drive_req(0, 1'b1, c0);
        drive_req(1, 1'b1, c1);
        step();
        drive_req(0, 1'b0, rand_cmd());
        drive_req(1, 1'b0, rand_cmd());
    endtask

    task automatic await_issue(input string tag, input cmd_t c, input int max);
        int w = 0;
        while (!bus.m_start && w < max) begin
            step();
            w++;
        end
        chk({tag, "_mstart"}, bus.m_start, 1'b1);
        chk({tag, "_mcmd"}, bus_cmd(), c);
    endtask

    // Entered on the cycle m_start is high; completes the access after lat WAIT cycles.
    task automatic serve(input string tag, input int n, input cmd_t c, input int lat,
                         input logic [DW-1:0] rd, input logic [1:0] st,
                         input bit junk, input bit restart, input cmd_t rc);
        for (int i = 1; i <= lat; i++) begin
            step();
            if (junk && i == 2) drive_req(n, 1'b0, rand_cmd());
            chk({tag, "_wait_mstart"}, bus.m_start, 1'b0);
            chk({tag, "_wait_cmd"}, bus_cmd(), c);
            chk({tag, "_wait_done"}, {req0_done, req1_done}, 2'b00);
            if (junk && i == 1) drive_req(n, 1'b1, rand_cmd());
        end
        bus.m_done = 1'b1; bus.m_rdata = rd; bus.m_access_status = st;
        step();
        bus.m_done = 1'b0; bus.m_rdata = $urandom; bus.m_access_status = 2'($urandom);
        if (junk) drive_req(n, 1'b0, rand_cmd());
        chk({tag, "_done"}, done_of(n), 1'b1);
        chk({tag, "_other_done"}, done_of(1 - n), 1'b0);
        chk({tag, "_rdata"}, rdata_of(n), rd);
        chk({tag, "_status"}, status_of(n), st);
        if (restart) drive_req(n, 1'b1, rc);
        step();
        if (restart) drive_req(n, 1'b0, rand_cmd());
        chk({tag, "_done_end"}, done_of(n), 1'b0);
        chk({tag, "_rdata_hold"}, rdata_of(n), rd);
    endtask

    task automatic check_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            step();
            chk({tag, "_idle_mstart"}, bus.m_start, 1'b0);
            chk({tag, "_idle_done"}, {req0_done, req1_done}, 2'b00);
        end
    endtask

    // Both requesters fire together; the model picks the order from tie_winner.
    task automatic serve_pair(input string tag, input cmd_t c0, input cmd_t c1);
        int first;
        cmd_t cf, cs;
        first = tie_winner;
        tie_winner = ~tie_winner;
        cf = (first == 0) ? c0 : c1;
        cs = (first == 0) ? c1 : c0;
        pulse_both(c0, c1);
        await_issue({tag, "_first"}, cf, 4);
        serve({tag, "_first"}, first, cf, $urandom_range(1, 5), $urandom, 2'($urandom),
              1'b0, 1'b0, cf);
        await_issue({tag, "_second"}, cs, 4);
        serve({tag, "_second"}, 1 - first, cs, $urandom_range(1, 5), $urandom, 2'($urandom),
              1'b0, 1'b0, cs);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t c, c2;
        bus.m_done = 1'b0; bus.m_rdata = '0; bus.m_access_status = 2'b00;

        step(); step();
        chk("reset_outputs", all_out(), '0);
        rst_n = 1'b1;
        step();

        serve_pair("pair_a", rand_cmd(), rand_cmd());
        serve_pair("pair_b", rand_cmd(), rand_cmd());
        check_idle("pairs", 2);

        c = '{addr: 32'h4, rnw: 1'b0, strb: 4'hF, wdata: 32'h1234_5678};
        pulse(0, c);
        chk("wr0_early_mstart", bus.m_start, 1'b0);
        step();
        await_issue("wr0", c, 0);
        step();
        chk("wr0_mstart_once", bus.m_start, 1'b0);
        serve("wr0", 0, c, 2, 32'h0, 2'b00, 1'b0, 1'b0, c);
        check_idle("wr0", 2);

        c = rand_cmd();
        c.rnw = 1'b1;
        pulse(1, c);
        await_issue("rd1", c, 4);
        serve("rd1", 1, c, 3, 32'hA5A5_A5A5, 2'b00, 1'b0, 1'b0, c);

        c = rand_cmd();
        pulse(0, c);
        await_issue("ign0", c, 4);
        serve("ign0", 0, c, 4, $urandom, 2'b10, 1'b1, 1'b0, c);
        check_idle("ign0", 4);

        c  = rand_cmd();
        c2 = rand_cmd();
        pulse(1, c);
        await_issue("rst1", c, 4);
        serve("rst1", 1, c, 2, $urandom, 2'b01, 1'b0, 1'b1, c2);
        await_issue("rst1_again", c2, 4);
        serve("rst1_again", 1, c2, 1, $urandom, 2'b00, 1'b0, 1'b0, c2);

        bus.m_done = 1'b1; bus.m_access_status = 2'b11;
        check_idle("mdone_idle", 3);
        bus.m_done = 1'b0;

        for (int it = 0; it < 24; it++) begin
            int mode;
            mode = $urandom_range(0, 2);
            if (mode == 2) begin
                serve_pair("rnd_pair", rand_cmd(), rand_cmd());
            end else begin
                c = rand_cmd();
                pulse(mode, c);
                await_issue("rnd_one", c, 4);
                serve("rnd_one", mode, c, $urandom_range(1, 6), $urandom, 2'($urandom),
                      1'($urandom_range(0, 1)), 1'b0, c);
            end
            check_idle("rnd", 1);
        end

        c = rand_cmd();
        pulse(1, c);
        await_issue("tmo", c, 4);
`ifdef AXI4_LITE_ARB_TIMEOUT_EN
        for (int i = 0; i < TO; i++) begin
            step();
            chk("tmo_wait_done", {req0_done, req1_done}, 2'b00);
        end
        step();
        chk("tmo_done", req1_done, 1'b1);
        chk("tmo_status", req1_status, 2'b11);
        chk("tmo_rdata", req1_rdata, 32'h0);
        check_idle("tmo", 2);
`else
        for (int i = 0; i < 40; i++) begin
            step();
            chk("notmo_wait_done", {req0_done, req1_done}, 2'b00);
        end
        serve("notmo", 1, c, 1, $urandom, 2'b01, 1'b0, 1'b0, c);
`endif

        c = rand_cmd();
        pulse(0, c);
        await_issue("rstwait", c, 4);
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("rstwait_outputs", all_out(), '0);
        step(); step();
        chk("rstwait_outputs_held", all_out(), '0);
        rst_n = 1'b1;
        tie_winner = 1'b0;
        check_idle("rstwait", 4);
        serve_pair("post_rst", rand_cmd(), rand_cmd());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
